video_timing_controller: RTL



---
 rtl/video_timing_pkg.sv | 26 ++
 rtl/video_timing_controller_axis.sv | 73 +++++++
 rtl/video_timing_controller.sv | 94 +++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared phase encoding, 1080p60 default timing and the axis-length helper
// for the video timing controller.
package video_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  localparam int H_ACTIVE_1080P = 1920;
  localparam int H_FRONT_1080P  = 88;
  localparam int H_SYNC_1080P   = 44;
  localparam int H_BACK_1080P   = 148;
  localparam int V_ACTIVE_1080P = 1080;
  localparam int V_FRONT_1080P  = 4;
  localparam int V_SYNC_1080P   = 5;
  localparam int V_BACK_1080P   = 36;

  function automatic int axis_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/video_timing_controller_axis.sv
// One raster axis: exact-width position counter, ACTIVE/FRONT/SYNC/BACK phase
// FSM and wrap tick. Exposes next-phase so the top can register outputs in step.
module timing_axis_fsm
  import video_timing_pkg::*;
#(
  parameter int active = H_ACTIVE_1080P,
  parameter int front  = H_FRONT_1080P,
  parameter int sync   = H_SYNC_1080P,
  parameter int back   = H_BACK_1080P,
  parameter int width  = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  input  logic             restart,
  output logic [width-1:0] count,
  output phase_t           next_phase,
  output logic             tick
);

  localparam int total = axis_total(active, front, sync, back);
  localparam logic [width-1:0] last     = width'(total - 1);
  localparam logic [width-1:0] front_at = width'(active);
  localparam logic [width-1:0] sync_at  = width'(active + front);
  localparam logic [width-1:0] back_at  = width'(active + front + sync);

  if (active < 1 || front < 1 || sync < 1 || back < 1) begin : g_bad_phase_len
    $error("timing_axis_fsm: every phase length must be at least 1");
  end
  if (total > (1 << width)) begin : g_bad_width
    $error("timing_axis_fsm: axis total does not fit in the counter width");
  end

  phase_t           phase;
  logic [width-1:0] next_count;
  logic [width-1:0] inc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      phase <= PH_ACTIVE;
    end else begin
      count <= next_count;
      phase <= next_phase;
    end
  end

  // Wrap (or a forced restart) wins over the increment, so the count never exceeds last.
  always_comb begin
    inc        = count + width'(1);
    next_count = count;
    next_phase = phase;
    if (advance) begin
      if (restart || count == last) begin
        next_count = '0;
        next_phase = PH_ACTIVE;
      end else begin
        next_count = inc;
        case (phase)
          PH_ACTIVE: if (inc == front_at) next_phase = PH_FRONT;
          PH_FRONT:  if (inc == sync_at)  next_phase = PH_SYNC;
          PH_SYNC:   if (inc == back_at)  next_phase = PH_BACK;
          default:   next_phase = phase;
        endcase
      end
    end
  end

  always_comb begin
    tick = advance && (count == last);
  end

endmodule

// File: rtl/video_timing_controller.sv
// Raster timing source: H/V counters with registered sync, data-enable and
// line/frame markers. Optional VTC_RESYNC_EN adds a resyncReq frame restart.
module video_timing_controller
  import video_timing_pkg::*;
#(
  parameter int hBusWidth = 12,
  parameter int vBusWidth = 11,
  parameter int hActive   = H_ACTIVE_1080P,
  parameter int hFront    = H_FRONT_1080P,
  parameter int hSyncLen  = H_SYNC_1080P,
  parameter int hBack     = H_BACK_1080P,
  parameter int vActive   = V_ACTIVE_1080P,
  parameter int vFront    = V_FRONT_1080P,
  parameter int vSyncLen  = V_SYNC_1080P,
  parameter int vBack     = V_BACK_1080P,
  parameter int hSyncPol  = 1,
  parameter int vSyncPol  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
`ifdef VTC_RESYNC_EN
  input  logic                 resyncReq,
`endif
  output logic [hBusWidth-1:0] hCount,
  output logic [vBusWidth-1:0] vCount,
  output logic                 hSync,
  output logic                 vSync,
  output logic                 dataEnable,
  output logic                 lineStart,
  output logic                 frameStart
);

  localparam logic hs_on = (hSyncPol != 0);
  localparam logic vs_on = (vSyncPol != 0);

  logic   running;
  logic   h_adv;
  logic   h_tick;
  logic   v_tick;
  logic   resync_now;
  phase_t h_next_phase;
  phase_t v_next_phase;

  assign h_adv = enable & running;

  timing_axis_fsm #(
    .active(hActive), .front(hFront), .sync(hSyncLen), .back(hBack), .width(hBusWidth)
  ) h_axis (
    .clock(clock), .reset(reset), .advance(h_adv), .restart(1'b0),
    .count(hCount), .next_phase(h_next_phase), .tick(h_tick)
  );

  timing_axis_fsm #(
    .active(vActive), .front(vFront), .sync(vSyncLen), .back(vBack), .width(vBusWidth)
  ) v_axis (
    .clock(clock), .reset(reset), .advance(h_tick), .restart(resync_now),
    .count(vCount), .next_phase(v_next_phase), .tick(v_tick)
  );

`ifdef VTC_RESYNC_EN
  logic pending;

  // A request on the line-tick edge itself is consumed on that tick.
  assign resync_now = pending | resyncReq;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pending <= 1'b0;
    else       pending <= resync_now & ~h_tick;
  end
`else
  assign resync_now = 1'b0;
`endif

  // Outputs are registered from next-state so they describe the position the counters now show.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      running    <= 1'b0;
      dataEnable <= 1'b0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
      hSync      <= ~hs_on;
      vSync      <= ~vs_on;
    end else if (enable) begin
      running    <= 1'b1;
      dataEnable <= (h_next_phase == PH_ACTIVE) && (v_next_phase == PH_ACTIVE);
      lineStart  <= (~running | h_tick) && (v_next_phase == PH_ACTIVE);
      frameStart <= ~running | v_tick | (h_tick & resync_now);
      hSync      <= (h_next_phase == PH_SYNC) ? hs_on : ~hs_on;
      vSync      <= (v_next_phase == PH_SYNC) ? vs_on : ~vs_on;
    end
  end

endmodule
